// File: rtl/knn_topk_ctrl_if.sv
// knn_topk_ctrl_if: command/response bus between the top-k
// controller and its attached min/max priority queue.
interface knn_topk_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
);
  logic                  q_enq_out;
  logic                  q_deq_smallest_out;
  logic                  q_deq_largest_out;
  logic [DATA_WIDTH-1:0] q_enq_data_out;
  logic [TAG_WIDTH-1:0]  q_enq_tag_out;
  logic                  q_valid_in;
  logic [DATA_WIDTH-1:0] q_data_in;
  logic [TAG_WIDTH-1:0]  q_tag_in;
  logic [TAG_WIDTH-1:0]  q_max_tag_in;

  modport master (
    output q_enq_out,
    output q_deq_smallest_out,
    output q_deq_largest_out,
    output q_enq_data_out,
    output q_enq_tag_out,
    input  q_valid_in,
    input  q_data_in,
    input  q_tag_in,
    input  q_max_tag_in
  );

  modport slave (
    input  q_enq_out,
    input  q_deq_smallest_out,
    input  q_deq_largest_out,
    input  q_enq_data_out,
    input  q_enq_tag_out,
    output q_valid_in,
    output q_data_in,
    output q_tag_in,
    output q_max_tag_in
  );
endinterface

// File: rtl/knn_topk_ctrl.sv
// knn_topk_ctrl: keeps the K nearest candidates in an attached
// priority queue, then drains them in ascending distance order.
module knn_topk_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32,
  parameter int K          = 8,
  parameter int SETTLE     = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   cand_valid_in,
  output logic                   cand_ready_out,
  input  logic [DATA_WIDTH-1:0]  cand_data_in,
  input  logic [TAG_WIDTH-1:0]   cand_dist_in,
  input  logic                   cand_last_in,
  knn_topk_ctrl_if.master        q,
  output logic                   res_valid_out,
  input  logic                   res_ready_in,
  output logic [DATA_WIDTH-1:0]  res_data_out,
  output logic [TAG_WIDTH-1:0]   res_dist_out,
  output logic                   res_last_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [$clog2(K):0]     occ_out
);

  localparam int OW = $clog2(K) + 1;
  localparam int GW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [OW-1:0] K_OCC  = OW'(K);
  localparam logic [GW-1:0] GAP_LD = GW'(SETTLE);

  typedef enum logic [3:0] {
    IDLE,
    ACCEPT,
    DECIDE,
    EVICT,
    ENQ,
    WAIT,
    DRAIN_CMD,
    DRAIN_WAIT,
    RESULT
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]  dist_q, dist_d;
  logic                  last_q, last_d;
  logic                  to_enq_q, to_enq_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TAG_WIDTH-1:0]  rdist_q, rdist_d;
  logic                  done_q, done_d;
  logic                  cmd_enq, cmd_dsm, cmd_dlg;

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      dist_q   <= '0;
      last_q   <= 1'b0;
      to_enq_q <= 1'b0;
      rdata_q  <= '0;
      rdist_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      dist_q   <= dist_d;
      last_q   <= last_d;
      to_enq_q <= to_enq_d;
      rdata_q  <= rdata_d;
      rdist_q  <= rdist_d;
      done_q   <= done_d;
    end
  end

  // Next state, queue commands and settle gap tracking
  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    data_d   = data_q;
    dist_d   = dist_q;
    last_d   = last_q;
    to_enq_d = to_enq_q;
    rdata_d  = rdata_q;
    rdist_d  = rdist_q;
    done_d   = 1'b0;
    cmd_enq  = 1'b0;
    cmd_dsm  = 1'b0;
    cmd_dlg  = 1'b0;
    gap_d    = (gap_q != '0) ? gap_q - 1'b1 : '0;

    unique case (state_q)
      IDLE: begin
        if (start_in) state_d = ACCEPT;
      end
      ACCEPT: begin
        if (cand_valid_in) begin
          data_d  = cand_data_in;
          dist_d  = cand_dist_in;
          last_d  = cand_last_in;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (occ_q < K_OCC) begin
          state_d = ENQ;
        end else if (dist_q < q.q_max_tag_in) begin
          state_d = EVICT;
        end else begin
          state_d = last_q ? DRAIN_CMD : ACCEPT;
        end
      end
      EVICT: begin
        cmd_dlg  = 1'b1;
        occ_d    = occ_q - 1'b1;
        to_enq_d = 1'b1;
        state_d  = WAIT;
      end
      ENQ: begin
        cmd_enq  = 1'b1;
        occ_d    = occ_q + 1'b1;
        to_enq_d = 1'b0;
        state_d  = WAIT;
      end
      WAIT: begin
        // Leave so the next command lands SETTLE+1 after the last
        if (gap_q <= GW'(1)) begin
          if (to_enq_q) state_d = ENQ;
          else if (last_q) state_d = DRAIN_CMD;
          else state_d = ACCEPT;
        end
      end
      DRAIN_CMD: begin
        if (gap_q == '0) begin
          cmd_dsm = 1'b1;
          occ_d   = occ_q - 1'b1;
          state_d = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (q.q_valid_in) begin
          rdata_d = q.q_data_in;
          rdist_d = q.q_tag_in;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_in) begin
          if (occ_q != '0) begin
            state_d = DRAIN_CMD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cmd_enq || cmd_dsm || cmd_dlg) gap_d = GAP_LD;
  end

  // Output decode from registered state
  always_comb begin
    q.q_enq_out          = cmd_enq;
    q.q_deq_smallest_out = cmd_dsm;
    q.q_deq_largest_out  = cmd_dlg;
    q.q_enq_data_out     = data_q;
    q.q_enq_tag_out      = dist_q;
    cand_ready_out       = (state_q == ACCEPT);
    res_valid_out        = (state_q == RESULT);
    res_last_out         = (state_q == RESULT) && (occ_q == '0);
    res_data_out         = rdata_q;
    res_dist_out         = rdist_q;
    busy_out             = (state_q != IDLE);
    done_out             = done_q;
    occ_out              = occ_q;
  end

endmodule

// File: tb/tb_knn_topk_ctrl.sv
// tb_knn_topk_ctrl: table vectors, hand sequences and random
// queries against a sorted-list reference with a queue model.
module tb_knn_topk_ctrl;

  localparam int DW     = 32;
  localparam int TW     = 32;
  localparam int K      = 4;
  localparam int SETTLE = 3;
  localparam int OW     = $clog2(K) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          cand_valid_in;
  logic          cand_ready_out;
  logic [DW-1:0] cand_data_in;
  logic [TW-1:0] cand_dist_in;
  logic          cand_last_in;
  logic          res_valid_out;
  logic          res_ready_in;
  logic [DW-1:0] res_data_out;
  logic [TW-1:0] res_dist_out;
  logic          res_last_out;
  logic          busy_out;
  logic          done_out;
  logic [OW-1:0] occ_out;

  knn_topk_ctrl_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) qif ();

  knn_topk_ctrl #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .K(K), .SETTLE(SETTLE)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .cand_valid_in(cand_valid_in),
    .cand_ready_out(cand_ready_out),
    .cand_data_in(cand_data_in),
    .cand_dist_in(cand_dist_in),
    .cand_last_in(cand_last_in),
    .q(qif.master),
    .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in),
    .res_data_out(res_data_out),
    .res_dist_out(res_dist_out),
    .res_last_out(res_last_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .occ_out(occ_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] fdat(input logic [31:0] d);
    return d * 32'h9E37 + 32'h1234;
  endfunction

  // Behavioural priority queue: one-cycle dequeue response
  logic [31:0] st_t[$];
  logic [31:0] st_d[$];
  int          q_over = 0;
  int          q_under = 0;
  int          qidx;
  logic [31:0] qmx;
  always @(posedge clk_in) begin
    qif.q_valid_in <= 1'b0;
    if (rst_in) begin
      st_t.delete();
      st_d.delete();
      qif.q_max_tag_in <= '0;
    end else begin
      if (qif.q_enq_out) begin
        st_t.push_back(qif.q_enq_tag_out);
        st_d.push_back(qif.q_enq_data_out);
        if (st_t.size() > K) q_over++;
      end
      if (qif.q_deq_smallest_out || qif.q_deq_largest_out) begin
        if (st_t.size() == 0) begin
          q_under++;
        end else begin
          qidx = 0;
          for (int i = 1; i < st_t.size(); i++) begin
            if (qif.q_deq_smallest_out ? (st_t[i] < st_t[qidx])
                                       : (st_t[i] > st_t[qidx]))
              qidx = i;
          end
          qif.q_valid_in <= 1'b1;
          qif.q_data_in  <= st_d[qidx];
          qif.q_tag_in   <= st_t[qidx];
          st_t.delete(qidx);
          st_d.delete(qidx);
        end
      end
      qmx = 0;
      foreach (st_t[i]) if (st_t[i] > qmx) qmx = st_t[i];
      qif.q_max_tag_in <= qmx;
    end
  end

  // Protocol monitor: spacing, one-hot pulses, occupancy bound
  int cyc = 0;
  int last_cmd = -1000;
  int spc_viol = 0;
  int multi_viol = 0;
  int occ_viol = 0;
  int ev_cnt = 0;
  int cmd_cnt = 0;
  int np;
  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      last_cmd = -1000;
    end else begin
      np = int'(qif.q_enq_out) + int'(qif.q_deq_smallest_out)
         + int'(qif.q_deq_largest_out);
      if (np > 1) multi_viol++;
      if (np > 0) begin
        if (cyc - last_cmd < SETTLE + 1) spc_viol++;
        last_cmd = cyc;
        cmd_cnt++;
        if (qif.q_deq_largest_out) ev_cnt++;
      end
      if (int'(occ_out) > K) occ_viol++;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    int              n;
    logic [7:0][7:0] d;
    int              nr;
    logic [3:0][7:0] r;
    int              ev;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] vd[16];
  int          vn;
  logic [31:0] got[$];
  logic [31:0] expq[$];

  task automatic feed_one(input logic [31:0] d, input logic l);
    int b = 0;
    cand_valid_in = 1'b1;
    cand_dist_in  = d;
    cand_data_in  = fdat(d);
    cand_last_in  = l;
    while (!cand_ready_out && b < 100) begin
      @(posedge clk_in); #1;
      b++;
    end
    if (b >= 100) chk("cand_timeout", 64'd1, 64'd0);
    @(posedge clk_in); #1;
    cand_valid_in = 1'b0;
    cand_last_in  = 1'b0;
  endtask

  task automatic drain(input int rrand);
    int b = 0;
    bit fin = 0;
    got.delete();
    while (!fin && b < 3000) begin
      res_ready_in = rrand != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_valid_out && res_ready_in) begin
        got.push_back(res_dist_out);
        chk("res_data", res_data_out, fdat(res_dist_out));
        if (res_last_out) fin = 1;
      end
      @(posedge clk_in); #1;
      b++;
    end
    res_ready_in = 1'b0;
    chk("drain_done", fin, 1);
    chk("done_pulse", done_out, 1);
    chk("busy_idle", busy_out, 0);
    chk("occ_idle", occ_out, 0);
    @(posedge clk_in); #1;
    chk("done_single", done_out, 0);
  endtask

  // Start held high through the feed phase: it must be ignored
  task automatic run_query(input int rrand, input int grand);
    start_in = 1'b1;
    @(posedge clk_in); #1;
    for (int i = 0; i < vn; i++) begin
      if (grand != 0 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk_in); #1; end
      feed_one(vd[i], i == vn - 1);
    end
    start_in = 1'b0;
    drain(rrand);
  endtask

  task automatic cmp_res(input string nm);
    chk({nm, "_count"}, got.size(), expq.size());
    for (int j = 0; j < got.size() && j < expq.size(); j++)
      chk({nm, "_dist"}, got[j], expq[j]);
  endtask

  // Reference: the K smallest distances, ascending
  task automatic build_exp(output int ev);
    logic [31:0] all[$];
    logic [31:0] kept[$];
    int mi;
    all.delete();
    kept.delete();
    ev = 0;
    for (int i = 0; i < vn; i++) begin
      all.push_back(vd[i]);
      if (kept.size() < K) begin
        kept.push_back(vd[i]);
      end else begin
        mi = 0;
        foreach (kept[j]) if (kept[j] > kept[mi]) mi = j;
        if (vd[i] < kept[mi]) begin
          kept[mi] = vd[i];
          ev++;
        end
      end
    end
    all.sort();
    expq.delete();
    for (int i = 0; i < all.size() && i < K; i++) expq.push_back(all[i]);
  endtask

  initial begin
    int ev0;
    int evx;
    int b;
    int c0;
    bit stab;

    tbl[0] = '{n:4, d:64'h0000000005070309, nr:4, r:32'h09070503, ev:0};
    tbl[1] = '{n:7, d:64'h0001080405070309, nr:4, r:32'h05040301, ev:2};
    tbl[2] = '{n:5, d:64'h0000000505050505, nr:4, r:32'h05050505, ev:0};
    tbl[3] = '{n:1, d:64'h000000000000002A, nr:1, r:32'h0000002A, ev:0};
    tbl[4] = '{n:6, d:64'h0000060504030201, nr:4, r:32'h04030201, ev:0};
    tbl[5] = '{n:8, d:64'h0102030405060708, nr:4, r:32'h04030201, ev:4};

    rst_in = 1'b1;
    start_in = 1'b0;
    cand_valid_in = 1'b0;
    cand_data_in = '0;
    cand_dist_in = '0;
    cand_last_in = 1'b0;
    res_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    chk("rst_busy", busy_out, 0);
    chk("rst_cready", cand_ready_out, 0);
    chk("rst_rvalid", res_valid_out, 0);
    chk("rst_occ", occ_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_enq_data", qif.q_enq_data_out, 0);

    for (int i = 0; i < 6; i++) begin
      vn = tbl[i].n;
      for (int j = 0; j < vn; j++) vd[j] = 32'(tbl[i].d[j]);
      expq.delete();
      for (int j = 0; j < tbl[i].nr; j++) expq.push_back(32'(tbl[i].r[j]));
      ev0 = ev_cnt;
      run_query(0, 0);
      cmp_res("tbl");
      chk("tbl_evicts", ev_cnt - ev0, tbl[i].ev);
    end

    // Single candidate, result held with ready low
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    feed_one(32'd42, 1'b1);
    b = 0;
    while (!res_valid_out && b < 100) begin
      @(posedge clk_in); #1;
      b++;
    end
    chk("stall_valid", res_valid_out, 1);
    c0 = cmd_cnt;
    stab = 1;
    repeat (10) begin
      if (!res_valid_out || res_dist_out != 42 ||
          res_data_out != fdat(32'd42) || !res_last_out) stab = 0;
      @(posedge clk_in); #1;
    end
    chk("stall_stable", stab, 1);
    chk("stall_no_cmd", cmd_cnt - c0, 0);
    res_ready_in = 1'b1;
    @(posedge clk_in); #1;
    res_ready_in = 1'b0;
    chk("stall_done", done_out, 1);

    // Reset while waiting out an eviction
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    feed_one(32'd9, 1'b0);
    feed_one(32'd3, 1'b0);
    feed_one(32'd7, 1'b0);
    feed_one(32'd5, 1'b0);
    feed_one(32'd4, 1'b0);
    b = 0;
    while (!qif.q_deq_largest_out && b < 50) begin
      @(posedge clk_in); #1;
      b++;
    end
    chk("evict_seen", qif.q_deq_largest_out, 1);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_occ", occ_out, 0);
    chk("mid_rst_pulses", {qif.q_enq_out, qif.q_deq_smallest_out,
                           qif.q_deq_largest_out}, 0);
    chk("mid_rst_outs", {res_valid_out, res_last_out, done_out,
                         cand_ready_out}, 0);
    chk("mid_rst_data", {qif.q_enq_data_out, qif.q_enq_tag_out}, 0);
    chk("mid_rst_res", {res_data_out, res_dist_out}, 0);
    vn = 2;
    vd[0] = 32'd2;
    vd[1] = 32'd1;
    expq.delete();
    expq.push_back(32'd1);
    expq.push_back(32'd2);
    run_query(0, 0);
    cmp_res("post_rst");

    // Random queries with ties, gaps and back-pressure
    for (int t = 0; t < 20; t++) begin
      vn = $urandom_range(1, 10);
      for (int j = 0; j < vn; j++) vd[j] = $urandom_range(0, 12);
      build_exp(evx);
      ev0 = ev_cnt;
      run_query(1, 1);
      cmp_res("rnd");
      chk("rnd_evicts", ev_cnt - ev0, evx);
    end

    chk("cmd_spacing", spc_viol, 0);
    chk("one_cmd", multi_viol, 0);
    chk("occ_bound", occ_viol, 0);
    chk("q_overflow", q_over, 0);
    chk("q_underflow", q_under, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_topk_ctrl.md
KNN_TOPK_CTRL -- requirements
Module: knn_topk_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, point payload width.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, distance width (unsigned).
REQ-003 SHALL have parameter K, default 8, neighbours kept; equals attached queue DEPTH.
REQ-004 SHALL have parameter SETTLE, default 3, idle cycles after every queue command.
REQ-005 SHALL have clk_in input 1: the single clock; all logic on posedge.
REQ-006 SHALL have rst_in input 1: reset, synchronous and active-high.
REQ-007 SHALL have start_in input 1: begin a query.
REQ-008 SHALL have cand_valid_in input 1, cand_ready_out output 1: candidate handshake.
REQ-009 SHALL have cand_data_in input DATA_WIDTH, cand_dist_in input TAG_WIDTH, cand_last_in input 1: candidate point, distance, final-candidate flag.
REQ-010 SHALL have q_enq_out, q_deq_smallest_out, q_deq_largest_out outputs 1: single-cycle queue command pulses.
REQ-011 SHALL have q_enq_data_out output DATA_WIDTH, q_enq_tag_out output TAG_WIDTH: enqueue operands.
REQ-012 SHALL have q_valid_in input 1, q_data_in input DATA_WIDTH, q_tag_in input TAG_WIDTH: queue dequeue result.
REQ-013 SHALL have q_max_tag_in input TAG_WIDTH: queue's registered largest stored tag.
REQ-014 SHALL have res_valid_out output 1, res_ready_in input 1, res_data_out output DATA_WIDTH, res_dist_out output TAG_WIDTH, res_last_out output 1: ascending result stream.
REQ-015 SHALL have busy_out output 1, done_out output 1, occ_out output $clog2(K)+1: status, completion pulse, stored-entry count.

Function
REQ-016 SHALL implement FSM states IDLE, ACCEPT, DECIDE, EVICT, ENQ, WAIT, DRAIN_CMD, DRAIN_WAIT, RESULT.
REQ-017 SHALL go IDLE->ACCEPT on start_in; start_in outside IDLE is ignored; busy_out=1 in every state except IDLE.
REQ-018 SHALL assert cand_ready_out only in ACCEPT; handshake (valid&&ready) latches data, dist, last and moves to DECIDE.
REQ-019 DECIDE: occ<K -> ENQ; occ==K and dist<q_max_tag_in -> EVICT; otherwise (including dist==max) discard -> ACCEPT, or DRAIN_CMD if latched last.
REQ-020 EVICT: pulse q_deq_largest_out one cycle, decrement occ, wait SETTLE cycles, then ENQ; dequeued result (q_valid_in) is ignored.
REQ-021 ENQ: pulse q_enq_out one cycle with latched operands, increment occ, then WAIT for SETTLE cycles -> ACCEPT, or DRAIN_CMD if latched last.
REQ-022 SHALL never issue two queue commands less than SETTLE+1 cycles apart; at most one command pulse high per cycle.
REQ-023 DRAIN_CMD: pulse q_deq_smallest_out, decrement occ -> DRAIN_WAIT; capture q_data_in/q_tag_in on q_valid_in -> RESULT.
REQ-024 RESULT: hold res_valid_out=1 with stable data until res_ready_in; res_last_out=1 iff occ==0; after handshake -> DRAIN_CMD if occ>0, else pulse done_out one cycle and -> IDLE.
REQ-025 Results SHALL emerge in non-decreasing distance order; count = min(K, candidates received).
REQ-026 Candidate with cand_last_in on first handshake SHALL still be stored and returned (res_last_out=1).
REQ-027 occ SHALL never exceed K nor underflow; occ_out mirrors occ.
REQ-028 res_ready_in low SHALL stall drain indefinitely without issuing queue commands.

Reset
REQ-029 rst_in at any cycle SHALL force IDLE, occ=0, all command pulses, res_valid_out, res_last_out, done_out, busy_out, cand_ready_out to 0, data/dist outputs to 0 next cycle; the queue shares rst_in, so a mid-query reset abandons the query.

Verification
REQ-030 K=4: start, distances 9,3,7,5 (last on 5) -> results 3,5,7,9, last on 9, done_out one pulse, occ_out back to 0.
REQ-031 K=4: distances 9,3,7,5,4,8,1 -> evictions of 9 then 7; 8 discarded; results 1,3,4,5.
REQ-032 K=4: distances 5,5,5,5,5 -> fifth discarded (tie); four results of 5, no EVICT pulse.
REQ-033 K=4: single candidate dist 42 with last -> one result 42, res_last_out=1; res_ready_in held low 10 cycles -> output stable, no queue pulse.
REQ-034 Reset asserted in EVICT wait -> next cycle IDLE, all outputs 0; new query 2,1 -> results 1,2.
REQ-035 Checker on every run: command spacing >= SETTLE+1 cycles, occ in [0,K], start_in during busy ignored.
